// File: rtl/bus_fabric.sv
// bus_fabric
// Address-decode interconnect between the CPU data port and N_SLAVES memory/IO
// slaves. Each master request becomes one registered transaction that is routed
// to the region selected by the top SEL_W address bits. Slow slaves stretch the
// transaction with s_busy. A wait that runs too long, or an access to an
// unmapped region, finishes with an error pulse.
//
// Ports
//   clk      : bus clock, rising edge
//   rst_n    : asynchronous active-low reset
//   m_req    : start a transaction, sampled only when idle
//   m_write  : direction, 1 = write, latched with m_req
//   m_addr   : full address, latched with m_req
//   m_wdata  : write data, latched with m_req
//   m_rdata  : registered read data
//   m_ready  : one-cycle completion pulse
//   m_err    : one-cycle error pulse, coincident with m_ready
//   s_cs     : registered one-hot slave select
//   s_addr   : slave-local offset (low address bits)
//   s_wdata  : latched write data
//   s_write  : latched direction, only asserted while s_cs is active
//   s_rdata  : packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_busy   : per-slave not-ready flags
module bus_fabric #(
    parameter int                  N_SLAVES = 4,
    parameter int                  ADDR_W   = 16,
    parameter int                  DATA_W   = 16,
    parameter int                  SEL_W    = 2,
    parameter logic [N_SLAVES-1:0] SLAVE_EN = 4'b0111,
    parameter int                  TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_req,
    input  logic                       m_write,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       m_ready,
    output logic                       m_err,
    output logic [N_SLAVES-1:0]        s_cs,
    output logic [ADDR_W-SEL_W-1:0]    s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic                       s_write,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [SEL_W-1:0]    sel_q;
    logic                write_q;
    logic [7:0]          cnt_q;

    logic [SEL_W-1:0]    req_sel;
    logic [N_SLAVES-1:0] req_onehot;
    logic                req_mapped;
    logic                sel_busy;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;

    assign req_sel     = m_addr[ADDR_W-1 -: SEL_W];
    assign req_mapped  = SLAVE_EN[req_sel];
    // Only the selected slave's busy/rdata matter; the rest are ignored.
    assign sel_busy    = s_busy[sel_q];
    assign sel_rdata   = s_rdata[sel_q*DATA_W +: DATA_W];
    // cnt_q counts busy WAIT edges already seen, so this edge is number cnt_q+1.
    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        req_onehot          = '0;
        req_onehot[req_sel] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (m_req) state_next = req_mapped ? ST_ACCESS : ST_ERR;
            end
            ST_ACCESS: state_next = ST_WAIT;
            ST_WAIT: begin
                if (!sel_busy)        state_next = ST_DONE;
                else if (timeout_hit) state_next = ST_ERR;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath. Outputs are registered on the edge that enters DONE/ERR, so
    // m_ready/m_err are high exactly while the FSM sits in those states and
    // s_cs is already low there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            s_cs    <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_write <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_req) begin
                        sel_q   <= req_sel;
                        write_q <= m_write;
                        s_addr  <= m_addr[ADDR_W-SEL_W-1:0];
                        s_wdata <= m_wdata;
                        if (req_mapped) begin
                            s_cs    <= req_onehot;
                            s_write <= m_write;
                        end else begin
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            if (!m_write) m_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= '0;
                end
                ST_WAIT: begin
                    if (!sel_busy) begin
                        if (!write_q) m_rdata <= sel_rdata;
                        s_cs    <= '0;
                        s_write <= 1'b0;
                        m_ready <= 1'b1;
                    end else if (timeout_hit) begin
                        if (!write_q) m_rdata <= '0;
                        s_cs    <= '0;
                        s_write <= 1'b0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
module tb_bus_fabric;

    logic        clk;
    logic        rst_n;
    logic        m_req;
    logic        m_write;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [3:0]  s_cs;
    logic [13:0] s_addr;
    logic [15:0] s_wdata;
    logic        s_write;
    logic [63:0] s_rdata;
    logic [3:0]  s_busy;

    int checks;
    int errors;

    bus_fabric #(
        .N_SLAVES(4),
        .ADDR_W  (16),
        .DATA_W  (16),
        .SEL_W   (2),
        .SLAVE_EN(4'b0111),
        .TIMEOUT (255)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_req  (m_req),
        .m_write(m_write),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .m_err  (m_err),
        .s_cs   (s_cs),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_write(s_write),
        .s_rdata(s_rdata),
        .s_busy (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request at a falling edge, wait for the sampling edge E0, sample
    // #1 later and drop m_req.
    task automatic issue(input logic [15:0] addr, input logic wr, input logic [15:0] data);
        @(negedge clk);
        m_req   = 1'b1;
        m_write = wr;
        m_addr  = addr;
        m_wdata = data;
        @(posedge clk);
        #1;
        m_req = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if ({m_rdata, m_ready, m_err, s_cs, s_addr, s_wdata, s_write} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h rdy=%b err=%b cs=%b addr=%h wdata=%h wr=%b, want all 0",
                     m_rdata, m_ready, m_err, s_cs, s_addr, s_wdata, s_write);
        end
    endtask

    task automatic test_read_region1;
        s_rdata[31:16] = 16'h1234;
        s_busy = 4'b1001;                // unselected slaves busy: must be ignored
        issue(16'h4010, 1'b0, 16'h0000); // after E0
        checks++;
        if (s_cs !== 4'b0010 || s_addr !== 14'h0010 || s_write !== 1'b0 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd1_access: cs=%b addr=%h wr=%b rdy=%b, want cs=0010 addr=0010 wr=0 rdy=0",
                     s_cs, s_addr, s_write, m_ready);
        end
        step; // E1
        checks++;
        if (m_ready !== 1'b0 || s_cs !== 4'b0010) begin
            errors++;
            $display("FAIL rd1_e1: rdy=%b cs=%b, want rdy=0 cs=0010", m_ready, s_cs);
        end
        step; // E2
        checks++;
        if (m_ready !== 1'b1 || m_err !== 1'b0 || m_rdata !== 16'h1234 || s_cs !== 4'b0000) begin
            errors++;
            $display("FAIL rd1_done: rdy=%b err=%b rdata=%h cs=%b, want rdy=1 err=0 rdata=1234 cs=0000",
                     m_ready, m_err, m_rdata, s_cs);
        end
        step; // E3
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd1_pulse: rdy=%b, want 0", m_ready);
        end
        s_busy = 4'b0000;
    endtask

    task automatic test_write_busy;
        int cs_cnt = 0;
        int rdy_cnt = 0;
        int err_cnt = 0;
        int bad_side = 0;
        s_busy = 4'b0100;
        issue(16'h8005, 1'b1, 16'hBEEF);  // sample after E0 is index 0
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step;
            if (s_cs === 4'b0100) begin
                cs_cnt++;
                if (s_wdata !== 16'hBEEF || s_write !== 1'b1 || s_addr !== 14'h0005) bad_side++;
            end
            if (m_ready === 1'b1) rdy_cnt++;
            if (m_err === 1'b1) err_cnt++;
            if (i == 11) s_busy = 4'b0000; // busy seen on WAIT edges E2..E11
        end
        checks++;
        if (cs_cnt != 12) begin
            errors++;
            $display("FAIL wr_cs_len: cs cycles=%0d, want 12", cs_cnt);
        end
        checks++;
        if (bad_side != 0) begin
            errors++;
            $display("FAIL wr_slave_side: bad cycles=%0d, want 0", bad_side);
        end
        checks++;
        if (rdy_cnt != 1 || err_cnt != 0) begin
            errors++;
            $display("FAIL wr_ready: ready=%0d err=%0d, want ready=1 err=0", rdy_cnt, err_cnt);
        end
        checks++;
        if (m_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL wr_rdata_kept: rdata=%h, want 1234", m_rdata);
        end
    endtask

    task automatic test_unmapped;
        issue(16'hC000, 1'b0, 16'h0000);
        checks++;
        if (s_cs !== 4'b0000 || m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL unmapped: cs=%b rdy=%b err=%b rdata=%h, want cs=0000 rdy=1 err=1 rdata=0000",
                     s_cs, m_ready, m_err, m_rdata);
        end
        step;
        checks++;
        if (m_ready !== 1'b0 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_pulse: rdy=%b err=%b, want 0 0", m_ready, m_err);
        end
    endtask

    task automatic test_timeout;
        int idx = -1;
        logic cs_before = 1'b0;
        s_rdata[47:32] = 16'h7777;
        s_busy = 4'b0100;
        issue(16'h8000, 1'b0, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            if (i > 0) step;
            if (i == 255) cs_before = (s_cs === 4'b0100);
            if (m_ready === 1'b1) begin
                idx = i;
                break;
            end
        end
        checks++;
        if (idx != 256) begin
            errors++;
            $display("FAIL timeout_latency: ready at edge %0d, want 256", idx);
        end
        checks++;
        if (m_err !== 1'b1 || s_cs !== 4'b0000 || m_rdata !== 16'h0000 || !cs_before) begin
            errors++;
            $display("FAIL timeout_err: err=%b cs=%b rdata=%h cs_held=%b, want err=1 cs=0000 rdata=0000 cs_held=1",
                     m_err, s_cs, m_rdata, cs_before);
        end
        step;
        checks++;
        if (m_ready !== 1'b0 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: rdy=%b err=%b, want 0 0", m_ready, m_err);
        end
        s_busy = 4'b0000;
    endtask

    task automatic test_reset_midwait;
        int rdy_cnt = 0;
        int idx = -1;
        s_rdata[31:16] = 16'hA5A5;
        s_busy = 4'b0010;
        issue(16'h4abc, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) step;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_rdata, m_ready, m_err, s_cs, s_addr, s_wdata, s_write} !== '0) begin
            errors++;
            $display("FAIL midwait_reset: rdata=%h rdy=%b err=%b cs=%b addr=%h wdata=%h wr=%b, want all 0",
                     m_rdata, m_ready, m_err, s_cs, s_addr, s_wdata, s_write);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        s_busy = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step;
            if (m_ready === 1'b1) rdy_cnt++;
        end
        checks++;
        if (rdy_cnt != 0) begin
            errors++;
            $display("FAIL midwait_no_ready: ready pulses=%0d, want 0", rdy_cnt);
        end
        issue(16'h4001, 1'b0, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step;
            if (m_ready === 1'b1) begin
                idx = i;
                break;
            end
        end
        checks++;
        if (idx != 2 || m_rdata !== 16'hA5A5 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_read: ready edge=%0d rdata=%h err=%b, want edge=2 rdata=a5a5 err=0",
                     idx, m_rdata, m_err);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  exp_cs [8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                    4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic        exp_rdy[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] exp_rd [8] = '{16'hA5A5, 16'hA5A5, 16'hAAAA, 16'hAAAA,
                                    16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555};
        s_rdata[15:0]  = 16'hAAAA;
        s_rdata[31:16] = 16'h5555;
        s_busy = 4'b0000;
        @(negedge clk);
        m_req   = 1'b1;
        m_write = 1'b0;
        m_addr  = 16'h0123;
        for (int i = 0; i < 8; i++) begin
            step;
            if (i == 0) m_addr = 16'h4321;
            if (i == 4) m_req = 1'b0;
            checks++;
            if (s_cs !== exp_cs[i] || m_ready !== exp_rdy[i] || m_rdata !== exp_rd[i] || m_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_edge%0d: cs=%b rdy=%b rdata=%h err=%b, want cs=%b rdy=%b rdata=%h err=0",
                         i, s_cs, m_ready, m_rdata, m_err, exp_cs[i], exp_rdy[i], exp_rd[i]);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        m_req   = 1'b0;
        m_write = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_busy  = '0;
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        step;
        test_read_region1;
        test_write_busy;
        test_unmapped;
        test_timeout;
        test_reset_midwait;
        step;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
